// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Purpose  : Two-master front end for memory_top. Arbitrates between the
//             instruction-fetch port (IF) and the load/store port (LS),
//             issues one transaction at a time on the memory_top bus, waits
//             for the completion strobe and returns the result to the granted
//             master with RISC-V load sign/zero extension applied.
//             Misaligned and illegal accesses are faulted locally and never
//             reach the bus.
//  Ports    : i_clk, i_rst_n              clock, async active-low reset
//             i_if_req/i_if_addr          fetch request (level) + word address
//             o_if_data/valid/fault       fetch result, one-cycle valid pulse
//             i_ls_req/we/funct3/addr/wdata  load/store request (level)
//             o_ls_rdata/valid/fault      load/store result, one-cycle pulse
//             o_bus_data/address/DV, o_bhw, o_write_notread  to memory_top
//             i_bus_data/i_bus_DV         from memory_top
//             o_busy                      high whenever the FSM is not IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter (
  input  logic        i_clk,
  input  logic        i_rst_n,
  // instruction-fetch port
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic [31:0] o_if_data,
  output logic        o_if_valid,
  output logic        o_if_fault,
  // load/store port
  input  logic        i_ls_req,
  input  logic        i_ls_we,
  input  logic [2:0]  i_ls_funct3,
  input  logic [31:0] i_ls_addr,
  input  logic [31:0] i_ls_wdata,
  output logic [31:0] o_ls_rdata,
  output logic        o_ls_valid,
  output logic        o_ls_fault,
  // memory_top bus
  output logic [31:0] o_bus_data,
  output logic [31:0] o_bus_address,
  output logic        o_bus_DV,
  output logic [2:0]  o_bhw,
  output logic        o_write_notread,
  input  logic [31:0] i_bus_data,
  input  logic        i_bus_DV,
  // status
  output logic        o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic C_GRANT_IF = 1'b0;
  localparam logic C_GRANT_LS = 1'b1;

  localparam logic [2:0] C_BHW_BYTE = 3'b001;
  localparam logic [2:0] C_BHW_HALF = 3'b010;
  localparam logic [2:0] C_BHW_WORD = 3'b100;

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  state_t      state_q,        state_d;
  logic        last_grant_q,   last_grant_d;
  logic        grant_q,        grant_d;
  logic        ls_we_q,        ls_we_d;
  logic [2:0]  ls_funct3_q,    ls_funct3_d;

  logic [31:0] if_data_q,      if_data_d;
  logic        if_valid_q,     if_valid_d;
  logic        if_fault_q,     if_fault_d;
  logic [31:0] ls_rdata_q,     ls_rdata_d;
  logic        ls_valid_q,     ls_valid_d;
  logic        ls_fault_q,     ls_fault_d;
  logic [31:0] bus_data_q,     bus_data_d;
  logic [31:0] bus_address_q,  bus_address_d;
  logic        bus_dv_q,       bus_dv_d;
  logic [2:0]  bhw_q,          bhw_d;
  logic        write_q,        write_d;
  logic        busy_q,         busy_d;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic        w_ls_code_ok;
  logic        w_ls_align_ok;
  logic        w_ls_legal;
  logic        w_if_legal;
  logic        w_pick_ls;
  logic        w_tie;
  logic [2:0]  w_ls_bhw;
  logic [31:0] w_load_ext;

  // funct3 legality depends on direction: stores have no unsigned variants.
  always_comb begin
    w_ls_code_ok = 1'b0;
    if (i_ls_we) begin
      case (i_ls_funct3)
        3'b000, 3'b001, 3'b010: w_ls_code_ok = 1'b1;
        default:                w_ls_code_ok = 1'b0;
      endcase
    end else begin
      case (i_ls_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_ls_code_ok = 1'b1;
        default:                                w_ls_code_ok = 1'b0;
      endcase
    end
  end

  // funct3[1:0] is the access size for both loads and stores.
  always_comb begin
    w_ls_align_ok = 1'b1;
    w_ls_bhw      = C_BHW_WORD;
    case (i_ls_funct3[1:0])
      2'b00: begin
        w_ls_align_ok = 1'b1;
        w_ls_bhw      = C_BHW_BYTE;
      end
      2'b01: begin
        w_ls_align_ok = ~i_ls_addr[0];
        w_ls_bhw      = C_BHW_HALF;
      end
      default: begin
        w_ls_align_ok = (i_ls_addr[1:0] == 2'b00);
        w_ls_bhw      = C_BHW_WORD;
      end
    endcase
  end

  assign w_ls_legal = w_ls_code_ok & w_ls_align_ok;
  assign w_if_legal = (i_if_addr[1:0] == 2'b00);
  assign w_tie      = i_if_req & i_ls_req;

  // On a tie the port that did not win the previous tie is served.
  assign w_pick_ls  = i_ls_req & (~i_if_req | (last_grant_q == C_GRANT_IF));

  // memory_top leaves stale upper bytes on i_bus_data, so only the bytes
  // belonging to the access size are used. Uses the funct3/we captured at
  // grant so the result does not depend on the requester's held fields.
  always_comb begin
    w_load_ext = i_bus_data;
    if (ls_we_q) begin
      w_load_ext = 32'h0;
    end else begin
      case (ls_funct3_q)
        3'b000:  w_load_ext = {{24{i_bus_data[7]}},  i_bus_data[7:0]};
        3'b100:  w_load_ext = {24'h0,                i_bus_data[7:0]};
        3'b001:  w_load_ext = {{16{i_bus_data[15]}}, i_bus_data[15:0]};
        3'b101:  w_load_ext = {16'h0,                i_bus_data[15:0]};
        default: w_load_ext = i_bus_data;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    ls_we_d       = ls_we_q;
    ls_funct3_d   = ls_funct3_q;

    if_data_d     = if_data_q;
    if_valid_d    = 1'b0;
    if_fault_d    = 1'b0;
    ls_rdata_d    = ls_rdata_q;
    ls_valid_d    = 1'b0;
    ls_fault_d    = 1'b0;
    // Bus fields hold their last value until the next legal grant.
    bus_data_d    = bus_data_q;
    bus_address_d = bus_address_q;
    bus_dv_d      = 1'b0;
    bhw_d         = bhw_q;
    write_d       = write_q;

    case (state_q)
      ST_IDLE: begin
        // A stray i_bus_DV here is deliberately ignored.
        if (i_if_req || i_ls_req) begin
          grant_d = w_pick_ls;
          if (w_tie) begin
            last_grant_d = w_pick_ls;
          end

          if (w_pick_ls == C_GRANT_LS) begin
            ls_we_d     = i_ls_we;
            ls_funct3_d = i_ls_funct3;
            if (w_ls_legal) begin
              bus_dv_d      = 1'b1;
              bus_address_d = i_ls_addr;
              bus_data_d    = i_ls_wdata;
              bhw_d         = w_ls_bhw;
              write_d       = i_ls_we;
              state_d       = ST_WAIT;
            end else begin
              ls_valid_d = 1'b1;
              ls_fault_d = 1'b1;
              ls_rdata_d = 32'h0;
              state_d    = ST_DONE;
            end
          end else begin
            if (w_if_legal) begin
              bus_dv_d      = 1'b1;
              bus_address_d = i_if_addr;
              bus_data_d    = 32'h0;
              bhw_d         = C_BHW_WORD;
              write_d       = 1'b0;
              state_d       = ST_WAIT;
            end else begin
              if_valid_d = 1'b1;
              if_fault_d = 1'b1;
              if_data_d  = 32'h0;
              state_d    = ST_DONE;
            end
          end
        end
      end

      ST_WAIT: begin
        if (i_bus_DV) begin
          if (grant_q == C_GRANT_LS) begin
            ls_valid_d = 1'b1;
            ls_rdata_d = w_load_ext;
          end else begin
            if_valid_d = 1'b1;
            if_data_d  = i_bus_data;
          end
          state_d = ST_DONE;
        end
      end

      // Single cycle; requests are not sampled so the requester can drop req.
      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= C_GRANT_IF;
      grant_q       <= C_GRANT_IF;
      ls_we_q       <= 1'b0;
      ls_funct3_q   <= 3'b000;
      if_data_q     <= 32'h0;
      if_valid_q    <= 1'b0;
      if_fault_q    <= 1'b0;
      ls_rdata_q    <= 32'h0;
      ls_valid_q    <= 1'b0;
      ls_fault_q    <= 1'b0;
      bus_data_q    <= 32'h0;
      bus_address_q <= 32'h0;
      bus_dv_q      <= 1'b0;
      bhw_q         <= 3'b000;
      write_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      ls_we_q       <= ls_we_d;
      ls_funct3_q   <= ls_funct3_d;
      if_data_q     <= if_data_d;
      if_valid_q    <= if_valid_d;
      if_fault_q    <= if_fault_d;
      ls_rdata_q    <= ls_rdata_d;
      ls_valid_q    <= ls_valid_d;
      ls_fault_q    <= ls_fault_d;
      bus_data_q    <= bus_data_d;
      bus_address_q <= bus_address_d;
      bus_dv_q      <= bus_dv_d;
      bhw_q         <= bhw_d;
      write_q       <= write_d;
      busy_q        <= busy_d;
    end
  end

  assign o_if_data       = if_data_q;
  assign o_if_valid      = if_valid_q;
  assign o_if_fault      = if_fault_q;
  assign o_ls_rdata      = ls_rdata_q;
  assign o_ls_valid      = ls_valid_q;
  assign o_ls_fault      = ls_fault_q;
  assign o_bus_data      = bus_data_q;
  assign o_bus_address   = bus_address_q;
  assign o_bus_DV        = bus_dv_q;
  assign o_bhw           = bhw_q;
  assign o_write_notread = write_q;
  assign o_busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_arbiter
//  Purpose  : Self-checking bench for mem_bus_arbiter. A memory_top stand-in
//             answers each bus strobe; a reference model predicts bus fields
//             and results per request, and one monitor compares every strobe
//             and every valid pulse against it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_if_req = 1'b0;
  logic [31:0] i_if_addr = '0;
  logic [31:0] o_if_data;
  logic        o_if_valid, o_if_fault;
  logic        i_ls_req = 1'b0;
  logic        i_ls_we = 1'b0;
  logic [2:0]  i_ls_funct3 = '0;
  logic [31:0] i_ls_addr = '0;
  logic [31:0] i_ls_wdata = '0;
  logic [31:0] o_ls_rdata;
  logic        o_ls_valid, o_ls_fault;
  logic [31:0] o_bus_data, o_bus_address;
  logic        o_bus_DV;
  logic [2:0]  o_bhw;
  logic        o_write_notread;
  logic [31:0] i_bus_data = '0;
  logic        i_bus_DV = 1'b0;
  logic        o_busy;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_data(o_if_data), .o_if_valid(o_if_valid), .o_if_fault(o_if_fault),
    .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_funct3(i_ls_funct3),
    .i_ls_addr(i_ls_addr), .i_ls_wdata(i_ls_wdata),
    .o_ls_rdata(o_ls_rdata), .o_ls_valid(o_ls_valid), .o_ls_fault(o_ls_fault),
    .o_bus_data(o_bus_data), .o_bus_address(o_bus_address), .o_bus_DV(o_bus_DV),
    .o_bhw(o_bhw), .o_write_notread(o_write_notread),
    .i_bus_data(i_bus_data), .i_bus_DV(i_bus_DV), .o_busy(o_busy)
  );

  // Expected outcome of one request.
  typedef struct packed {
    logic        legal;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  bhw;
    logic        wnr;
    logic [31:0] ret;
    logic [31:0] result;
  } exp_t;

  exp_t exp_if, exp_ls;
  logic order_q[$];        // expected grant order: 0 = IF, 1 = LS
  logic m_last = 1'b0;     // model of last tie winner
  logic inflight_v = 1'b0, inflight_p = 1'b0;
  logic seen_strobe = 1'b0;
  logic mon_p, mon_have;
  exp_t mon_e;
  int   gap = 0;
  int   resp_cnt = 0;
  int   n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, want);
  endtask

  // Access size in bytes is 2^funct3[1:0]; bhw is its one-hot form.
  function automatic exp_t model_ls(input logic we, input logic [2:0] f3,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [31:0] ret);
    exp_t e;
    int size, bits;
    logic code_ok;
    logic [31:0] mask, v;
    size    = 1 << f3[1:0];
    code_ok = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e.legal = code_ok && ((addr % 32'(size)) == 32'd0);
    e.addr  = addr;
    e.wdata = wdata;
    e.bhw   = 3'(size);
    e.wnr   = we;
    e.ret   = ret;
    bits    = 8 * size;
    if (!e.legal || we) e.result = 32'd0;
    else if (bits >= 32) e.result = ret;
    else begin
      mask = (32'd1 << bits) - 32'd1;
      v    = ret & mask;
      if (!f3[2] && v[bits-1]) v = v | ~mask;
      e.result = v;
    end
    return e;
  endfunction

  function automatic exp_t model_if(input logic [31:0] addr, input logic [31:0] ret);
    exp_t e;
    e.legal  = (addr % 32'd4) == 32'd0;
    e.addr   = addr;
    e.wdata  = 32'd0;
    e.bhw    = 3'b100;
    e.wnr    = 1'b0;
    e.ret    = ret;
    e.result = e.legal ? ret : 32'd0;
    return e;
  endfunction

  // Both ports request together: the one that lost the previous tie wins.
  task automatic push_tie();
    logic w;
    w = ~m_last;
    m_last = w;
    order_q.push_back(w);
    order_q.push_back(~w);
  endtask

  // memory_top stand-in: completion strobe two cycles after the bus strobe.
  always @(posedge clk) begin
    #1;
    i_bus_DV = 1'b0;
    if (resp_cnt == 1) begin
      i_bus_DV   = 1'b1;
      i_bus_data = inflight_p ? exp_ls.ret : exp_if.ret;
    end
    if (resp_cnt > 0) resp_cnt--;
    if (o_bus_DV) resp_cnt = 2;
  end

  // Compare process.
  always @(negedge clk) begin
    if (!rst_n) begin
      inflight_v  = 1'b0;
      seen_strobe = 1'b0;
    end else begin
      gap = gap + 1;
      if (o_bus_DV) begin
        check("strobe_overlap", 32'(inflight_v), 32'd0);
        if (order_q.size() == 0) begin
          check("unexpected_strobe", 32'(o_bus_DV), 32'd0);
        end else begin
          mon_p = order_q.pop_front();
          mon_e = mon_p ? exp_ls : exp_if;
          check("strobe_legal", 32'(o_bus_DV), 32'(mon_e.legal));
          if (seen_strobe) check("strobe_gap", 32'(gap >= 3), 32'd1);
          check("bus_address", o_bus_address, mon_e.addr);
          check("bus_data", o_bus_data, mon_e.wdata);
          check("bus_bhw", 32'(o_bhw), 32'(mon_e.bhw));
          check("bus_write", 32'(o_write_notread), 32'(mon_e.wnr));
          check("busy_wait", 32'(o_busy), 32'd1);
          seen_strobe = 1'b1;
          gap         = 0;
          inflight_v  = 1'b1;
          inflight_p  = mon_p;
        end
      end
      if (o_if_valid || o_ls_valid) begin
        check("valid_one_port", 32'(o_if_valid && o_ls_valid), 32'd0);
        mon_have = 1'b1;
        if (inflight_v) begin
          mon_p = inflight_p;
          inflight_v = 1'b0;
        end else if (order_q.size() > 0) begin
          mon_p = order_q.pop_front();
        end else begin
          mon_have = 1'b0;
          check("unexpected_valid", 32'(o_if_valid | o_ls_valid), 32'd0);
        end
        if (mon_have) begin
          mon_e = mon_p ? exp_ls : exp_if;
          check("valid_port", 32'(o_ls_valid), 32'(mon_p));
          check("result_data", mon_p ? o_ls_rdata : o_if_data, mon_e.result);
          check("result_fault", 32'(mon_p ? o_ls_fault : o_if_fault), 32'(!mon_e.legal));
          check("busy_done", 32'(o_busy), 32'd1);
        end
      end
    end
  end

  task automatic ls_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] ret,
                       output logic [31:0] got, output logic flt, output int lat);
    logic done;
    exp_ls = model_ls(we, f3, addr, wdata, ret);
    @(posedge clk); #1;
    i_ls_we = we; i_ls_funct3 = f3; i_ls_addr = addr; i_ls_wdata = wdata; i_ls_req = 1'b1;
    lat = 0; got = '0; flt = 1'b0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk); lat++;
      if (o_ls_valid) begin got = o_ls_rdata; flt = o_ls_fault; done = 1'b1; end
    end
    if (!done) check("ls_timeout", 32'(o_ls_valid), 32'd1);
    @(posedge clk); #1;
    i_ls_req = 1'b0;
  endtask

  task automatic if_op(input logic [31:0] addr, input logic [31:0] ret,
                       output logic [31:0] got, output logic flt, output int lat);
    logic done;
    exp_if = model_if(addr, ret);
    @(posedge clk); #1;
    i_if_addr = addr; i_if_req = 1'b1;
    lat = 0; got = '0; flt = 1'b0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk); lat++;
      if (o_if_valid) begin got = o_if_data; flt = o_if_fault; done = 1'b1; end
    end
    if (!done) check("if_timeout", 32'(o_if_valid), 32'd1);
    @(posedge clk); #1;
    i_if_req = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_bus_DV"}, 32'(o_bus_DV), 32'd0);
    check({tag, "_bus_addr"}, o_bus_address, 32'd0);
    check({tag, "_bus_data"}, o_bus_data, 32'd0);
    check({tag, "_bhw_wr"}, {28'd0, o_bhw, o_write_notread}, 32'd0);
    check({tag, "_valids"}, {28'd0, o_if_valid, o_if_fault, o_ls_valid, o_ls_fault}, 32'd0);
    check({tag, "_data"}, o_if_data | o_ls_rdata, 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
  endtask

  logic [31:0] g1, g2;
  logic        f1, f2;
  int          l1, l2;

  initial begin
    repeat (3) @(posedge clk);
    #1 check_idle_zero("reset");
    rst_n = 1'b1;

    // Tie right after reset: LS first, then IF.
    push_tie();
    fork
      ls_op(1'b0, 3'b010, 32'h300, 32'd0, 32'hCAFEF00D, g1, f1, l1);
      if_op(32'h104, 32'h00112233, g2, f2, l2);
    join
    check("tie1_ls_first", 32'(l1 < l2), 32'd1);
    check("tie1_ls_data", g1, 32'hCAFEF00D);
    check("tie1_if_data", g2, 32'h00112233);

    // Second tie alternates: IF first.
    push_tie();
    fork
      ls_op(1'b0, 3'b100, 32'h301, 32'd0, 32'h123456F0, g1, f1, l1);
      if_op(32'h108, 32'h0A0B0C0D, g2, f2, l2);
    join
    check("tie2_if_first", 32'(l2 < l1), 32'd1);
    check("tie2_lbu_data", g1, 32'h000000F0);

    // Plain fetch.
    order_q.push_back(1'b0);
    if_op(32'h100, 32'hDEADBEEF, g1, f1, l1);
    check("fetch_data", g1, 32'hDEADBEEF);
    check("fetch_fault", 32'(f1), 32'd0);
    check("fetch_latency", 32'(l1), 32'd5);

    // Loads with sign/zero extension.
    order_q.push_back(1'b1);
    ls_op(1'b0, 3'b000, 32'h203, 32'd0, 32'h12345680, g1, f1, l1);
    check("lb_data", g1, 32'hFFFFFF80);
    check("lb_bhw", 32'(o_bhw), 32'd1);
    order_q.push_back(1'b1);
    ls_op(1'b0, 3'b100, 32'h203, 32'd0, 32'h12345680, g1, f1, l1);
    check("lbu_data", g1, 32'h00000080);
    order_q.push_back(1'b1);
    ls_op(1'b0, 3'b001, 32'h202, 32'd0, 32'hAAAA8001, g1, f1, l1);
    check("lh_data", g1, 32'hFFFF8001);
    order_q.push_back(1'b1);
    ls_op(1'b0, 3'b101, 32'h202, 32'd0, 32'hAAAA8001, g1, f1, l1);
    check("lhu_data", g1, 32'h00008001);
    order_q.push_back(1'b1);
    ls_op(1'b0, 3'b010, 32'h204, 32'd0, 32'h87654321, g1, f1, l1);
    check("lw_data", g1, 32'h87654321);

    // Stores.
    order_q.push_back(1'b1);
    ls_op(1'b1, 3'b001, 32'h402, 32'h0000BEEF, 32'hFFFFFFFF, g1, f1, l1);
    check("sh_rdata", g1, 32'd0);
    check("sh_bus_data", o_bus_data, 32'h0000BEEF);
    check("sh_bhw", 32'(o_bhw), 32'd2);
    check("sh_write", 32'(o_write_notread), 32'd1);
    order_q.push_back(1'b1);
    ls_op(1'b1, 3'b000, 32'h407, 32'h11223344, 32'h55555555, g1, f1, l1);
    check("sb_rdata", g1, 32'd0);

    // Faults: valid+fault one cycle after grant, never on the bus.
    order_q.push_back(1'b1);
    ls_op(1'b0, 3'b010, 32'h101, 32'd0, 32'd0, g1, f1, l1);
    check("lw_mis_fault", 32'(f1), 32'd1);
    check("lw_mis_latency", 32'(l1), 32'd2);
    order_q.push_back(1'b1);
    ls_op(1'b1, 3'b011, 32'h200, 32'h12345678, 32'd0, g1, f1, l1);
    check("sb011_fault", 32'(f1), 32'd1);
    check("sb011_latency", 32'(l1), 32'd2);
    order_q.push_back(1'b0);
    if_op(32'h102, 32'h0, g1, f1, l1);
    check("if_mis_fault", 32'(f1), 32'd1);
    order_q.push_back(1'b1);
    ls_op(1'b0, 3'b001, 32'h201, 32'd0, 32'd0, g1, f1, l1);
    order_q.push_back(1'b1);
    ls_op(1'b0, 3'b110, 32'h200, 32'd0, 32'd0, g1, f1, l1);
    order_q.push_back(1'b1);
    ls_op(1'b1, 3'b100, 32'h200, 32'd0, 32'd0, g1, f1, l1);
    check("s100_fault", 32'(f1), 32'd1);

    // Reset during WAIT; the late completion strobe must be dropped.
    exp_ls = model_ls(1'b0, 3'b010, 32'h500, 32'd0, 32'h77777777);
    @(posedge clk); #1;
    i_ls_we = 1'b0; i_ls_funct3 = 3'b010; i_ls_addr = 32'h500; i_ls_req = 1'b1;
    @(posedge clk); #2;
    check("rstw_strobe", 32'(o_bus_DV), 32'd1);
    #1 rst_n = 1'b0; i_ls_req = 1'b0;
    #1 check_idle_zero("rstw");
    @(posedge clk); #3 rst_n = 1'b1;
    m_last = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("rstw_after_busy", 32'(o_busy), 32'd0);
    end

    // Tie after reset: LS wins again (LS faults, IF legal).
    push_tie();
    fork
      ls_op(1'b0, 3'b011, 32'h600, 32'd0, 32'd0, g1, f1, l1);
      if_op(32'h10C, 32'h13579BDF, g2, f2, l2);
    join
    check("tie3_ls_first", 32'(l1 < l2), 32'd1);
    check("tie3_ls_fault", 32'(f1), 32'd1);
    check("tie3_if_data", g2, 32'h13579BDF);

    repeat (4) @(posedge clk);
    check("order_drained", 32'(order_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
